// File: rtl/mem_if_pkg.sv
// Shared definitions for memory-port arbiters: FSM encoding, default widths,
// and a rotated-priority winner function that other arbiters can reuse.
// Pure package: no logic, no latency, no flow control of its own.
package mem_if_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Largest requester count the winner function handles.
    localparam int RR_MAX_REQ = 8;

    // Search order is last+1, last+2, ... wrapping modulo n, so the previous
    // winner is examined last. Bits of valid at or above n must be zero.
    // Returns 0 when nothing is valid; callers qualify with their own any-valid.
    function automatic logic [2:0] rr_winner(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [2:0]            last,
        input int                    n
    );
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX_REQ; i++) begin
            idx = 3'((int'(last) + i) % n);
            if ((i <= n) && !found && valid[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Round-robin picker: rotates req_valid so the slot after last is highest priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on winner.
//   valid     in  NUM_REQ  requests to consider
//   last      in  IDX_W    previously granted index (lowest priority now)
//   winner    out IDX_W    chosen index, meaningful only when any_valid
//   any_valid out 1        at least one request present
module rr_picker
    import mem_if_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    always_comb begin
        winner    = IDX_W'(rr_winner(RR_MAX_REQ'(valid), 3'(last), NUM_REQ));
        any_valid = |valid;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory request port among NUM_REQ requesters.
// Latency: grant visible as mem_valid the cycle after req_valid in IDLE; req_ready same cycle as mem_ready.
// Backpressure: requesters hold req_valid until their req_ready; at least one IDLE cycle between transactions.
//   req_valid/req_write/req_addr/req_wdata  in   per-requester request and payload (packed by index)
//   req_ready/req_rdata                     out  completion pulse to the granted requester, broadcast read data
//   mem_valid/mem_write/mem_addr/mem_wdata  out  latched request towards the AXI-Lite master
//   mem_ready/mem_rdata                     in   completion from the AXI-Lite master
//   grant_id/busy                           out  current or last granted index, transaction in flight
module mem_req_arbiter
    import mem_if_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_valid,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    state_t           state, state_n;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             take;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid     (req_valid),
        .last      (last),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Next state; take marks the cycle the winner's payload is captured.
    // mem_ready outside BUSY falls through to the default and is ignored.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_n = ST_BUSY;
                    take    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            if (take) begin
                mem_write <= req_write[winner];
                mem_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                grant_id  <= winner;
                last      <= winner;
            end
        end
    end

    // The completion pulse is steered straight from mem_ready so the
    // requester sees it in the same cycle the master reports completion.
    always_comb begin
        req_ready = '0;
        if ((state == ST_BUSY) && mem_ready) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign req_rdata = mem_rdata;
    assign mem_valid = (state == ST_BUSY);
    assign busy      = (state == ST_BUSY);

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single CPU-side memory request port (mem_addr/mem_wdata/mem_write/mem_valid/mem_rdata/mem_ready) of the AXI-Lite master between NUM_REQ requesters, e.g. cpu_core and a DMA engine.
- Sits between the requesters and axi_lite_master.
- Round-robin arbitration with one outstanding transaction at a time.
- Requester payload is registered at grant, so downstream sees stable signals for the whole transaction.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- IDX_W, $clog2(NUM_REQ) (min 1), grant index width (localparam).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until matching req_ready.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  DATA_W  read data, broadcast; valid only with req_ready.
- mem_valid  out  1  request to axi_lite_master.
- mem_write  out  1  latched write flag.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_ready  in  1  completion pulse from axi_lite_master.
- mem_rdata  in  DATA_W  read data from axi_lite_master.
- grant_id  out  IDX_W  index of current/last granted requester.
- busy  out  1  high while a transaction is in flight.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; mem_valid=0; mem_write=0; mem_addr=0; mem_wdata=0.
  - req_ready=0; busy=0; grant_id=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM, two states:
  - IDLE: if any req_valid, pick winner w = first i with req_valid[i] when searching (last+1)..(last+NUM_REQ) mod NUM_REQ. Latch addr/wdata/write of w into mem_* regs. Set grant_id=w, last=w, go BUSY. If no req_valid, stay IDLE.
  - BUSY: mem_valid=1, busy=1. On mem_ready: req_ready[grant_id]=1 (combinational from mem_ready & BUSY), req_rdata=mem_rdata passthrough, next state IDLE.
- Latency:
  - req_valid seen in IDLE cycle N gives mem_valid high at N+1.
  - mem_ready at cycle M gives req_ready in the same cycle M, and mem_valid low at M+1.
  - Minimum 1 IDLE cycle between back-to-back transactions, so the requester can drop req_valid.
- Handshake rules:
  - Inputs of non-granted requesters are ignored while BUSY.
  - mem_* payload is constant from grant until mem_ready.
  - mem_valid is never deasserted before mem_ready.
- Fairness:
  - The requester granted last has lowest priority next time.
  - With all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- Boundary conditions:
  - Single requester active repeatedly: granted every time, since wrap-around reaches it.
  - req_valid dropping while not granted is legal; it is simply not considered.
  - mem_ready while IDLE is a protocol error and is ignored: no req_ready pulse, no state change.
  - rst mid-transaction forces IDLE and mem_valid=0 next edge. rst must be applied to axi_lite_master in the same cycle, so no orphan response is delivered.
  - req_rdata is undefined outside req_ready cycles; zero is not required.

Decomposition:
- Shared package mem_if_pkg:
  - state encoding (ST_IDLE, ST_BUSY).
  - default ADDR_W/DATA_W constants.
  - a function computing the rotated priority winner, reusable by other arbiters.
- One natural sub-module: rr_picker. Combinational rotate/priority-encode of req_valid given last; outputs winner index and any_valid.

Test Plan:
- Single read, NUM_REQ=2: req_valid[0]=1, addr 0x1000_0004, write=0. Expected: mem_valid high next cycle with mem_addr 0x1000_0004. Then mem_ready with rdata 0xDEADBEEF gives req_ready=2'b01 and req_rdata=0xDEADBEEF in the same cycle.
- Simultaneous requests after reset: both req_valid high (req0 write 0x11 to 0x4000_0000, req1 read 0x4000_0004). Expected: req0 granted first, then req1. mem_addr sequence 0x4000_0000, 0x4000_0004; grant_id 0 then 1.
- Continuous contention for 6 transactions, mem_ready after 3 cycles each. Expected grant_id sequence 0,1,0,1,0,1; no requester waits more than one transaction.
- Payload stability: change req_addr[1] to 0xFFFF_FFFF while req1 is BUSY. Expected: mem_addr keeps the latched value until mem_ready.
- Spurious mem_ready in IDLE. Expected: req_ready stays 0, state stays IDLE, busy=0.
- rst asserted 2 cycles into a BUSY write. Expected: next cycle mem_valid=0, busy=0, grant_id=0, req_ready=0. After release, a pending req1 is served with its fresh payload.
